// File: rtl/zebra_detection_filter.sv
// zebra_detection_filter: temporal debounce of per-frame zebra crossing
// verdicts. Adds confirm/release hysteresis, a running confidence
// average and a staleness timeout.
module zebra_detection_filter #(
  parameter int CONFIRM_COUNT  = 3,
  parameter int RELEASE_COUNT  = 4,
  parameter int MIN_CONFIDENCE = 128,
  parameter int MIN_STRIPES    = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        detection_valid,
  input  logic        crossing_detected,
  input  logic [7:0]  stripe_count,
  input  logic [15:0] confidence,
  output logic        crossing_confirmed,
  output logic        confirm_change,
  output logic [15:0] avg_confidence,
  output logic [1:0]  filter_state,
  output logic        stale
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0]   MIN_CONF_W = 16'(MIN_CONFIDENCE);
  localparam logic [7:0]    MIN_STR_W  = 8'(MIN_STRIPES);
  localparam logic [3:0]    CONF_W     = 4'(CONFIRM_COUNT);
  localparam logic [3:0]    REL_W      = 4'(RELEASE_COUNT);
  localparam logic [IW-1:0] TMO_W      = IW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CANDIDATE = 2'd1,
    CONFIRMED = 2'd2,
    RELEASING = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    pos_cnt, pos_nx, neg_cnt, neg_nx;
  logic [IW-1:0] idle_cnt, idle_nx;
  logic          stale_nx, confirmed_nx, qual, timeout;
  logic [17:0]   avg_sum;
  logic [15:0]   avg_nx;

  assign qual = crossing_detected && (confidence >= MIN_CONF_W) &&
                (stripe_count >= MIN_STR_W);

  // Idle counter saturates; timeout fires when it sits at the limit with no
  // strobe, so a strobe landing on the limit cycle wins.
  always_comb begin
    if (detection_valid)       idle_nx = '0;
    else if (idle_cnt != TMO_W) idle_nx = idle_cnt + 1'b1;
    else                       idle_nx = idle_cnt;
    timeout = !detection_valid && (idle_nx == TMO_W);
  end

  // State register: FSM, hysteresis counters, idle counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      pos_cnt            <= '0;
      neg_cnt            <= '0;
      idle_cnt           <= '0;
      stale              <= 1'b0;
      crossing_confirmed <= 1'b0;
      confirm_change     <= 1'b0;
      avg_confidence     <= '0;
    end else begin
      state              <= state_nx;
      pos_cnt            <= pos_nx;
      neg_cnt            <= neg_nx;
      idle_cnt           <= idle_nx;
      stale              <= stale_nx;
      crossing_confirmed <= confirmed_nx;
      confirm_change     <= confirmed_nx != crossing_confirmed;
      avg_confidence     <= avg_nx;
    end
  end

  // Next-state logic: timeout forces IDLE; otherwise only a strobe advances.
  always_comb begin
    state_nx = state;
    pos_nx   = pos_cnt;
    neg_nx   = neg_cnt;
    stale_nx = stale;
    if (timeout) begin
      state_nx = IDLE;
      pos_nx   = '0;
      neg_nx   = '0;
      stale_nx = 1'b1;
    end else if (detection_valid) begin
      stale_nx = 1'b0;
      case (state)
        IDLE: if (qual) begin
          state_nx = CANDIDATE;
          pos_nx   = 4'd1;
        end
        CANDIDATE: if (qual) begin
          if (pos_cnt + 4'd1 == CONF_W) begin
            state_nx = CONFIRMED;
            pos_nx   = '0;
          end else begin
            pos_nx = pos_cnt + 4'd1;
          end
        end else begin
          state_nx = IDLE;
          pos_nx   = '0;
        end
        CONFIRMED: if (!qual) begin
          state_nx = RELEASING;
          neg_nx   = 4'd1;
        end
        RELEASING: if (!qual) begin
          if (neg_cnt + 4'd1 == REL_W) begin
            state_nx = IDLE;
            neg_nx   = '0;
          end else begin
            neg_nx = neg_cnt + 4'd1;
          end
        end else begin
          state_nx = CONFIRMED;
          neg_nx   = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs. The 18-bit sum
  // cannot overflow (3*0xFFFF + 0xFFFF < 2^18).
  always_comb begin
    confirmed_nx = (state_nx == CONFIRMED) || (state_nx == RELEASING);
    avg_sum      = 18'(avg_confidence) * 18'd3 + 18'(confidence);
    avg_nx       = detection_valid ? avg_sum[17:2] : avg_confidence;
  end

  assign filter_state = state;
endmodule

// File: tb/tb_zebra_detection_filter.sv
// Bench for zebra_detection_filter: table vectors, hand-written corner
// sequences and randomized traffic against a run-length reference model.
module tb_zebra_detection_filter;
  localparam int CONF_N = 3;
  localparam int REL_N  = 4;
  localparam int TMO    = 50;

  logic        clk = 0;
  logic        rst_n;
  logic        detection_valid, crossing_detected;
  logic [7:0]  stripe_count;
  logic [15:0] confidence;
  logic        crossing_confirmed, confirm_change, stale;
  logic [15:0] avg_confidence;
  logic [1:0]  filter_state;

  zebra_detection_filter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .detection_valid(detection_valid),
    .crossing_detected(crossing_detected), .stripe_count(stripe_count),
    .confidence(confidence), .crossing_confirmed(crossing_confirmed),
    .confirm_change(confirm_change), .avg_confidence(avg_confidence),
    .filter_state(filter_state), .stale(stale)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the verdict flips after a run of opposing samples.
  bit m_conf, m_stale, m_change;
  int m_run, m_idle, m_avg, m_state;

  function automatic void model_reset();
    m_conf = 0; m_stale = 0; m_change = 0;
    m_run = 0; m_idle = 0; m_avg = 0; m_state = 0;
  endfunction

  function automatic void model_step(bit v, bit cd, int sc, int cf);
    bit prev = m_conf;
    bit q;
    if (v) begin
      m_idle = 0; m_stale = 0;
      m_avg = (3 * m_avg + cf) / 4;
      q = cd && cf >= 128 && sc >= 4;
      if (q != m_conf) begin
        m_run++;
        if (m_run == (m_conf ? REL_N : CONF_N)) begin
          m_conf = !m_conf; m_run = 0;
        end
      end else m_run = 0;
    end else begin
      if (m_idle < TMO) m_idle++;
      if (m_idle == TMO) begin m_stale = 1; m_conf = 0; m_run = 0; end
    end
    m_change = prev != m_conf;
    m_state = m_conf ? (m_run != 0 ? 3 : 2) : (m_run != 0 ? 1 : 0);
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic step(input bit v, input bit cd, input int sc, input int cf);
    detection_valid = v; crossing_detected = cd;
    stripe_count = 8'(sc); confidence = 16'(cf);
    @(posedge clk); #1;
    model_step(v, cd, sc, cf);
    n_vec++;
    if (filter_state != 2'(m_state) || crossing_confirmed != m_conf ||
        confirm_change != m_change || avg_confidence != 16'(m_avg) ||
        stale != m_stale) begin
      n_bad++;
      $display("FAIL model t=%0t: st/cc/ch/avg/stale got %0d/%0d/%0d/%0h/%0d expected %0d/%0d/%0d/%0h/%0d",
               $time, filter_state, crossing_confirmed, confirm_change, avg_confidence, stale,
               m_state, m_conf, m_change, m_avg, m_stale);
    end
  endtask

  typedef struct {
    bit v; bit cd; int sc; int cf;
    int st; bit cc; bit ch;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(bit cd, int sc, int cf, int st, bit cc, bit ch);
    vec_t r;
    r.v = 1; r.cd = cd; r.sc = sc; r.cf = cf; r.st = st; r.cc = cc; r.ch = ch;
    return r;
  endfunction

  initial begin
    int prev_avg;
    // confirm: 3 qualifying strobes
    tbl[0]  = mk(1, 6, 200, 1, 0, 0);
    tbl[1]  = mk(1, 6, 200, 1, 0, 0);
    tbl[2]  = mk(1, 6, 200, 2, 1, 1);
    // neg, neg, pos, 4x neg
    tbl[3]  = mk(1, 6, 50,  3, 1, 0);
    tbl[4]  = mk(1, 6, 50,  3, 1, 0);
    tbl[5]  = mk(1, 6, 200, 2, 1, 0);
    tbl[6]  = mk(1, 6, 50,  3, 1, 0);
    tbl[7]  = mk(1, 6, 50,  3, 1, 0);
    tbl[8]  = mk(1, 6, 50,  3, 1, 0);
    tbl[9]  = mk(1, 6, 50,  0, 0, 1);
    // threshold boundaries
    tbl[10] = mk(1, 6, 127, 0, 0, 0);
    tbl[11] = mk(1, 3, 200, 0, 0, 0);
    tbl[12] = mk(0, 6, 200, 0, 0, 0);
    tbl[13] = mk(1, 4, 128, 1, 0, 0);
    tbl[14] = mk(1, 4, 128, 1, 0, 0);
    tbl[15] = mk(1, 4, 128, 2, 1, 1);

    rst_n = 0; detection_valid = 0; crossing_detected = 0;
    stripe_count = 0; confidence = 0;
    model_reset();
    #3;
    chk("reset_state", filter_state, 0);
    chk("reset_conf", crossing_confirmed, 0);
    chk("reset_avg", avg_confidence, 0);
    chk("reset_stale", stale, 0);
    @(negedge clk); rst_n = 1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].cd, tbl[i].sc, tbl[i].cf);
      chk($sformatf("tbl%0d_state", i), filter_state, tbl[i].st);
      chk($sformatf("tbl%0d_conf", i), crossing_confirmed, tbl[i].cc);
      chk($sformatf("tbl%0d_chg", i), confirm_change, tbl[i].ch);
    end

    // timeout from CONFIRMED
    for (int i = 1; i < TMO; i++) step(0, 0, 0, 0);
    chk("pre_tmo_stale", stale, 0);
    chk("pre_tmo_state", filter_state, 2);
    step(0, 0, 0, 0);
    chk("tmo_stale", stale, 1);
    chk("tmo_state", filter_state, 0);
    chk("tmo_chg", confirm_change, 1);
    step(0, 0, 0, 0);
    chk("tmo_chg_once", confirm_change, 0);
    step(1, 1, 6, 200);
    chk("unstale", stale, 0);
    chk("unstale_state", filter_state, 1);
    step(1, 1, 6, 200);
    step(1, 1, 6, 200);
    chk("reconfirm", filter_state, 2);
    // strobe exactly on the timeout cycle wins
    for (int i = 1; i < TMO; i++) step(0, 0, 0, 0);
    step(1, 1, 6, 200);
    chk("tmo_race_stale", stale, 0);
    chk("tmo_race_state", filter_state, 2);

    // running average with 0xFFFF samples from 0
    @(negedge clk); rst_n = 0; model_reset(); #1;
    chk("rst_avg_state", filter_state, 0);
    @(negedge clk); rst_n = 1;
    prev_avg = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 6, 16'hFFFF);
      if (i == 0) chk("avg_first", avg_confidence, 16'h3FFF);
      if (i == 1) chk("avg_second", avg_confidence, 16'h6FFF);
      chk("avg_mono", int'(avg_confidence >= 16'(prev_avg)), 1);
      prev_avg = avg_confidence;
    end

    // reset asserted mid-CANDIDATE discards partial count
    step(1, 1, 6, 200);
    step(1, 1, 6, 200);
    chk("cand_state", filter_state, 1);
    rst_n = 0; #1;
    model_reset();
    chk("async_rst_state", filter_state, 0);
    chk("async_rst_avg", avg_confidence, 0);
    #2 rst_n = 1;
    step(1, 1, 6, 200);
    chk("post_rst_state", filter_state, 1);

    // randomized traffic with occasional long gaps
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        int gap = $urandom_range(TMO - 3, TMO + 5);
        for (int j = 0; j < gap; j++) step(0, 0, 0, 0);
      end else if ($urandom_range(0, 1) == 1) begin
        step(1, 1'($urandom_range(0, 3) != 0), $urandom_range(2, 7),
             $urandom_range(0, 3) == 0 ? $urandom_range(0, 65535) : $urandom_range(110, 150));
      end else begin
        step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 65535));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
